// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader: serialises instruction words into nibble writes; LOADER_CHECKSUM_EN adds a 16-bit word checksum port.
module instruction_memory_loader #(
  parameter int unsigned NIBBLES_PER_WORD = 4,
  parameter int unsigned MEM_DEPTH = 65536
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [31:0]                   startAddress,
  input  logic                          wordValid,
  input  logic [4*NIBBLES_PER_WORD-1:0] wordData,
  output logic                          wordReady,
  input  logic                          finish,
  output logic                          memWriteEnable,
  output logic [31:0]                   memWriteAddress,
  output logic [3:0]                    memWriteData,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [31:0]                   wordCount
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                   checksum
`endif
);
  localparam int unsigned WW = 4 * NIBBLES_PER_WORD;
  localparam int unsigned IW = $clog2(NIBBLES_PER_WORD + 1);
  localparam logic [1:0] IDLE = 2'd0, ACCEPT = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES_PER_WORD);
  logic [1:0] state_q, state_d;
  logic [31:0] ptr_q, ptr_d, cnt_q, cnt_d, addr_q, addr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WW-1:0] word_q, word_d;
  logic [3:0] data_q, data_d;
  logic fin_q, fin_d, ovf_q, ovf_d, done_q, done_d, busy_q, busy_d, we_q, we_d;
  logic [15:0] csum_q, csum_d;
  logic room, hs;
  // 33-bit compare so a pointer near 2^32 cannot wrap into range
  assign room = ({1'b0, ptr_q} + 33'(NIBBLES_PER_WORD)) <= 33'(MEM_DEPTH);
  assign wordReady = (state_q == ACCEPT) && room;
  assign hs = wordValid && wordReady;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    idx_d = idx_q;
    word_d = word_q;
    data_d = data_q;
    fin_d = fin_q;
    ovf_d = ovf_q;
    csum_d = csum_q;
    we_d = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = ACCEPT;
        ptr_d = startAddress;
        cnt_d = '0;
        ovf_d = 1'b0;
        fin_d = 1'b0;
        csum_d = '0;
      end
      ACCEPT: if (!room) begin
        state_d = DONE;
        ovf_d = 1'b1;
      end else if (hs) begin
        state_d = WRITE;
        word_d = wordData;
        fin_d = finish;
        csum_d = csum_q + 16'(wordData);
        we_d = 1'b1;
        addr_d = ptr_q;
        data_d = wordData[3:0];
        idx_d = IW'(1);
      end else if (finish) begin
        state_d = DONE;
      end
      WRITE: if (idx_q == LAST) begin
        state_d = (fin_q || finish) ? DONE : ACCEPT;
        ptr_d = ptr_q + NIBBLES_PER_WORD;
        cnt_d = cnt_q + 32'd1;
      end else begin
        we_d = 1'b1;
        addr_d = ptr_q + 32'(idx_q);
        data_d = 4'(word_q >> {idx_q, 2'b00});
        idx_d = idx_q + IW'(1);
        fin_d = fin_q || finish;
      end
    endcase
    busy_d = (state_d == ACCEPT) || (state_d == WRITE);
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      idx_q <= '0;
      word_q <= '0;
      data_q <= '0;
      fin_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      we_q <= 1'b0;
      csum_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      idx_q <= idx_d;
      word_q <= word_d;
      data_q <= data_d;
      fin_q <= fin_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
      busy_q <= busy_d;
      we_q <= we_d;
      csum_q <= csum_d;
    end
  end
  assign memWriteEnable = we_q;
  assign memWriteAddress = addr_q;
  assign memWriteData = data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign overflow = ovf_q;
  assign wordCount = cnt_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum = csum_q;
`else
  logic unused_csum;
  assign unused_csum = ^csum_q;
`endif
endmodule
